tof_counter: RTL



---
 rtl/tof_counter_if.sv | 37 +++
 rtl/tof_counter.sv | 119 +++++++++++
 2 files changed

// File: rtl/tof_counter_if.sv
// Measurement-stage port bundle: synchronized start/stop strobes in, range
// result and status strobes out. The slave modport is the counter side.
interface tof_counter_if #(
  parameter int CNT_W = 16,
  parameter int SEQ_W = 8
);
  logic             start_pulse;
  logic             stop_pulse;
  logic [CNT_W-1:0] range_count;
  logic             valid;
  logic             timeout;
  logic             busy;
  logic             start_ignored;
  logic [SEQ_W-1:0] seq_num;

  modport master (
    output start_pulse,
    output stop_pulse,
    input  range_count,
    input  valid,
    input  timeout,
    input  busy,
    input  start_ignored,
    input  seq_num
  );

  modport slave (
    input  start_pulse,
    input  stop_pulse,
    output range_count,
    output valid,
    output timeout,
    output busy,
    output start_ignored,
    output seq_num
  );
endinterface

// File: rtl/tof_counter.sv
// Time-of-flight interval counter: counts cycles from start to the first stop
// outside the blanking window, with timeout for missing echoes.
module tof_counter #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned BLANK_CYC   = 8,
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned SEQ_W       = 8
) (
  input  logic          clk,
  input  logic          rst,
  tof_counter_if.slave  tif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ARMED = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] BLANK_V   = CNT_W'(BLANK_CYC);
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] range_count_q, range_count_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             busy_q, busy_d;
  logic             start_ignored_q, start_ignored_d;
  logic [SEQ_W-1:0] seq_num_q, seq_num_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      range_count_q   <= '0;
      valid_q         <= 1'b0;
      timeout_q       <= 1'b0;
      busy_q          <= 1'b0;
      start_ignored_q <= 1'b0;
      seq_num_q       <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      range_count_q   <= range_count_d;
      valid_q         <= valid_d;
      timeout_q       <= timeout_d;
      busy_q          <= busy_d;
      start_ignored_q <= start_ignored_d;
      seq_num_q       <= seq_num_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    range_count_d   = range_count_q;
    valid_d         = 1'b0;
    timeout_d       = 1'b0;
    busy_d          = busy_q;
    start_ignored_d = 1'b0;
    seq_num_d       = seq_num_q;

    unique case (state_q)
      IDLE: begin
        // stop is deliberately not looked at here, even alongside start
        if (tif.start_pulse) begin
          cnt_d   = CNT_ONE;
          busy_d  = 1'b1;
          state_d = (BLANK_CYC == 0) ? ARMED : BLANK;
        end
      end

      BLANK: begin
        start_ignored_d = tif.start_pulse;
        cnt_d           = cnt_q + 1'b1;
        if (cnt_q == BLANK_V) begin
          state_d = ARMED;
        end
      end

      ARMED: begin
        start_ignored_d = tif.start_pulse;
        // stop takes priority over a timeout landing on the same cycle
        if (tif.stop_pulse) begin
          range_count_d = cnt_q;
          valid_d       = 1'b1;
          seq_num_d     = seq_num_q + 1'b1;
          busy_d        = 1'b0;
          cnt_d         = '0;
          state_d       = IDLE;
        end else if (cnt_q == TIMEOUT_V) begin
          timeout_d = 1'b1;
          seq_num_d = seq_num_q + 1'b1;
          busy_d    = 1'b0;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign tif.range_count   = range_count_q;
  assign tif.valid         = valid_q;
  assign tif.timeout       = timeout_q;
  assign tif.busy          = busy_q;
  assign tif.start_ignored = start_ignored_q;
  assign tif.seq_num       = seq_num_q;

endmodule
